// File: rtl/net_pkg.sv
// Shared definitions for the collective-router network: packet and communicator
// field layout, opcodes and the ejection-side state encodings.
package net_pkg;

  localparam int unsigned AddrW = 9;
  localparam int unsigned PktW  = 85;

  // Packet field offsets and widths
  localparam int unsigned PortLsb   = 82;
  localparam int unsigned PortW     = 3;
  localparam int unsigned ValidBit  = 81;
  localparam int unsigned DstLsb    = 72;
  localparam int unsigned SrcLsb    = 63;
  localparam int unsigned OriginLsb = 54;
  localparam int unsigned CtxLsb    = 46;
  localparam int unsigned CtxW      = 8;
  localparam int unsigned SeqLsb    = 38;
  localparam int unsigned SeqW      = 8;
  localparam int unsigned RsvdLsb   = 36;
  localparam int unsigned OpLsb     = 32;
  localparam int unsigned OpW       = 4;
  localparam int unsigned PayLsb    = 0;
  localparam int unsigned PayW      = 32;

  // Communicator config (newcomm) layout
  localparam int unsigned CommW        = 61;
  localparam int unsigned CommValidBit = 60;
  localparam int unsigned CommCtxLsb   = 52;
  localparam int unsigned CommChildLsb = 31;
  localparam int unsigned ChildW       = 3;

  // Opcodes
  localparam logic [3:0] OpScan           = 4'h0;
  localparam logic [3:0] OpBroadcast      = 4'h1;
  localparam logic [3:0] OpShortGather    = 4'h8;
  localparam logic [3:0] OpLargeGather    = 4'h9;
  localparam logic [3:0] OpShortAllGather = 4'hA;
  localparam logic [3:0] OpLargeAllGather = 4'hB;
  localparam logic [3:0] OpShortReduce    = 4'hC;
  localparam logic [3:0] OpLargeReduce    = 4'hD;
  localparam logic [3:0] OpShortAllReduce = 4'hE;
  localparam logic [3:0] OpLargeAllReduce = 4'hF;

  typedef enum logic [1:0] {ClsNone, ClsDrop, ClsPass, ClsReduce} pkt_class_e;
  typedef enum logic [1:0] {StIdle, StAccum, StEmit} red_state_e;

  // All four reduce-class opcodes live in 4'hC..4'hF.
  function automatic logic is_reduce_op(input logic [OpW-1:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// Synchronous show-ahead FIFO. Depth must be a power of two >= 2.
// A write while full is accepted if a read retires the head in the same cycle.
module eject_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 85
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_fire, rd_fire;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  // Head is forced to zero when empty so the output never shows stale/unknown data.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array, no reset needed since reads are gated by the empty flag.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_fire && !rd_fire)      count_q <= count_q + (AW + 1)'(1);
      else if (rd_fire && !wr_fire) count_q <= count_q - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/eject_collector.sv
// Per-node ejection endpoint: filters ejected packets by address/communicator,
// sums reduce-class contributions from children and queues results for the host.
// Optional: define EJECT_SEQ_CHECK_EN to drop reduce packets whose seq differs
// from the accumulation in progress.
module eject_collector
  import net_pkg::*;
#(
  parameter logic [8:0]  MY_ADDR    = 9'b0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [84:0]      in_eject,
  input  logic [60:0]      newcomm,
  output logic [84:0]      out_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err
);

  logic [CtxW-1:0]   ctx_q;
  logic [ChildW-1:0] children_q;
  logic              comm_load;

  logic [PktW-1:0]   pkt_q;
  pkt_class_e        cls_q, cls_d;

  red_state_e        state_q, state_d;
  logic [PayW-1:0]   acc_q, acc_d;
  logic [ChildW-1:0] cnt_q, cnt_d;
  logic [PktW-1:0]   hdr_q, hdr_d;

  logic              err_q;
  logic [CNT_W-1:0]  drop_q;

  logic              fifo_full, fifo_empty, fifo_wr, can_wr;
  logic [PktW-1:0]   fifo_wdata, emit_pkt;
  logic              pass_wr, pass_drop, emit_wr, red_drop, err_set, drop_evt;
  logic              is_red, seq_ok;

  logic unused_comm;
  assign unused_comm = ^{newcomm[51:34], newcomm[30:0]};

  assign comm_load = newcomm[CommValidBit];

  // Communicator config register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_q      <= '0;
      children_q <= '0;
    end else if (comm_load) begin
      ctx_q      <= newcomm[CommCtxLsb +: CtxW];
      children_q <= newcomm[CommChildLsb +: ChildW];
    end
  end

  // Classify against the config in force before this edge, so a newcomm load
  // only affects packets registered at later edges.
  always_comb begin
    cls_d = ClsNone;
    if (in_eject[ValidBit]) begin
      if (in_eject[DstLsb +: AddrW] != MY_ADDR)    cls_d = ClsDrop;
      else if (in_eject[CtxLsb +: CtxW] != ctx_q)  cls_d = ClsDrop;
      else if (is_reduce_op(in_eject[OpLsb +: OpW]) && (children_q != '0)) cls_d = ClsReduce;
      else                                         cls_d = ClsPass;
    end
  end

  // Input register: every valid packet is captured together with its class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q <= '0;
      cls_q <= ClsNone;
    end else begin
      cls_q <= cls_d;
      if (in_eject[ValidBit]) pkt_q <= in_eject;
    end
  end

  // FIFO write arbitration: pass-through first, reduce result only in a free slot.
  assign can_wr    = !fifo_full || out_ready;
  assign pass_wr   = (cls_q == ClsPass) && can_wr;
  assign pass_drop = (cls_q == ClsPass) && !can_wr;
  assign emit_wr   = (state_q == StEmit) && (cls_q != ClsPass) && can_wr;
  assign fifo_wr   = pass_wr || emit_wr;

  always_comb begin
    emit_pkt                     = hdr_q;
    emit_pkt[SrcLsb +: AddrW]    = MY_ADDR;
    emit_pkt[ValidBit]           = 1'b1;
    emit_pkt[PayLsb +: PayW]     = acc_q;
  end

  assign fifo_wdata = pass_wr ? pkt_q : emit_pkt;

  assign is_red = (cls_q == ClsReduce);

`ifdef EJECT_SEQ_CHECK_EN
  assign seq_ok = (pkt_q[SeqLsb +: SeqW] == hdr_q[SeqLsb +: SeqW]);
`else
  assign seq_ok = 1'b1;
`endif

  // Reduce FSM next-state: collect `children` contributions, then emit one sum.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    err_set  = 1'b0;
    red_drop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_red) begin
          acc_d   = pkt_q[PayLsb +: PayW];
          hdr_d   = pkt_q;
          cnt_d   = ChildW'(1);
          // <= 1 also covers a config changed to zero children in flight.
          state_d = (children_q <= ChildW'(1)) ? StEmit : StAccum;
        end
      end
      StAccum: begin
        if (comm_load) begin
          state_d  = StIdle;
          err_set  = 1'b1;
          red_drop = is_red;
        end else if (is_red) begin
          if (seq_ok) begin
            acc_d = acc_q + pkt_q[PayLsb +: PayW];
            cnt_d = cnt_q + ChildW'(1);
            if (cnt_d >= children_q) state_d = StEmit;
          end else begin
            red_drop = 1'b1;
            err_set  = 1'b1;
          end
        end
      end
      StEmit: begin
        if (is_red) begin
          red_drop = 1'b1;
          err_set  = 1'b1;
        end
        if (emit_wr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reduce FSM state and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
    end
  end

  // At most one packet is retired per cycle, so one drop event per cycle suffices.
  assign drop_evt = (cls_q == ClsDrop) || pass_drop || red_drop;

  // Saturating drop counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (drop_evt && (drop_q != '1)) drop_q <= drop_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  eject_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (PktW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (out_ready),
    .rd_data_o (out_pkt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign drop_cnt  = drop_q;
  assign err       = err_q;

endmodule

// File: tb/tb_eject_collector.sv
// Directed bench for eject_collector (MY_ADDR=0, FIFO_DEPTH=4).
module tb_eject_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [84:0] in_eject;
  logic [60:0] newcomm;
  logic [84:0] out_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] drop_cnt;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_drop     = 0;

  eject_collector #(
    .MY_ADDR    (9'b0),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_eject  (in_eject),
    .newcomm   (newcomm),
    .out_pkt   (out_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [84:0] mk_pkt(input logic [8:0] dst, input logic [8:0] src,
                                         input logic [7:0] ctx, input logic [7:0] seq,
                                         input logic [3:0] op, input logic [31:0] pay);
    logic [84:0] p;
    p        = '0;
    p[81]    = 1'b1;
    p[80:72] = dst;
    p[71:63] = src;
    p[62:54] = 9'h03;
    p[53:46] = ctx;
    p[45:38] = seq;
    p[35:32] = op;
    p[31:0]  = pay;
    return p;
  endfunction

  function automatic logic [60:0] mk_comm(input logic [7:0] ctx, input logic [2:0] ch);
    logic [60:0] c;
    c        = '0;
    c[60]    = 1'b1;
    c[59:52] = ctx;
    c[33:31] = ch;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_comm(input logic [2:0] ch);
    newcomm = mk_comm(8'h00, ch);
    tick();
    newcomm = '0;
    tick();
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_eject = '0; newcomm = '0; out_ready = 1'b0;
    tick(); tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    tests_run++;
    if (out_pkt !== 85'd0) begin
      tests_failed++; $display("FAIL reset_pkt: got %h want 0", out_pkt);
    end
    tests_run++;
    if (drop_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_drop: got %0d want 0", drop_cnt);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_err: got %0b want 0", err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass();
    logic [84:0] p;
    p = mk_pkt(9'd0, 9'd5, 8'h00, 8'h00, 4'hB, 32'd6);
    in_eject = p;
    tick();
    in_eject = '0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL pass_early: got %0b want 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL pass_valid: got %0b want 1", out_valid);
    end
    tests_run++;
    if (out_pkt !== p) begin
      tests_failed++; $display("FAIL pass_pkt: got %h want %h", out_pkt, p);
    end
    tests_run++;
    if (drop_cnt !== 16'(exp_drop)) begin
      tests_failed++; $display("FAIL pass_drop: got %0d want %0d", drop_cnt, exp_drop);
    end
    pop_one();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL pass_pop: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_filter();
    in_eject = mk_pkt(9'd1, 9'd5, 8'h00, 8'h00, 4'hB, 32'd6);
    tick();
    in_eject = mk_pkt(9'd0, 9'd5, 8'h05, 8'h00, 4'hB, 32'd7);
    tick();
    in_eject = '0;
    tick(); tick(); tick();
    exp_drop += 2;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL filter_valid: got %0b want 0", out_valid);
    end
    tests_run++;
    if (drop_cnt !== 16'(exp_drop)) begin
      tests_failed++; $display("FAIL filter_drop: got %0d want %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reduce3();
    logic [84:0] exp;
    load_comm(3'd3);
    in_eject = mk_pkt(9'd0, 9'd5, 8'h00, 8'h00, 4'hC, 32'd6); tick();
    in_eject = mk_pkt(9'd0, 9'd6, 8'h00, 8'h00, 4'hC, 32'd7); tick();
    in_eject = mk_pkt(9'd0, 9'd7, 8'h00, 8'h00, 4'hC, 32'd8); tick();
    in_eject = '0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL red3_early: got %0b want 0", out_valid);
    end
    tick();
    exp = mk_pkt(9'd0, 9'd0, 8'h00, 8'h00, 4'hC, 32'd21);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL red3_valid: got %0b want 1", out_valid);
    end
    tests_run++;
    if (out_pkt !== exp) begin
      tests_failed++; $display("FAIL red3_pkt: got %h want %h", out_pkt, exp);
    end
    pop_one();
    tick(); tick(); tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL red3_extra: got %0b want 0", out_valid);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL red3_err: got %0b want 0", err);
    end
  endtask

  task automatic test_wrap();
    load_comm(3'd2);
    in_eject = mk_pkt(9'd0, 9'd5, 8'h00, 8'h01, 4'hD, 32'hFFFF_FFFF); tick();
    in_eject = mk_pkt(9'd0, 9'd6, 8'h00, 8'h01, 4'hD, 32'd2); tick();
    in_eject = '0;
    tick(); tick();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL wrap_valid: got %0b want 1", out_valid);
    end
    tests_run++;
    if (out_pkt[31:0] !== 32'd1) begin
      tests_failed++; $display("FAIL wrap_sum: got %h want 1", out_pkt[31:0]);
    end
    pop_one();
  endtask

  task automatic test_seq();
    in_eject = mk_pkt(9'd0, 9'd5, 8'h00, 8'h00, 4'hC, 32'd10); tick();
    in_eject = mk_pkt(9'd0, 9'd6, 8'h00, 8'h01, 4'hC, 32'd20); tick();
    in_eject = '0;
    tick(); tick(); tick();
`ifdef EJECT_SEQ_CHECK_EN
    exp_drop += 1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL seq_valid: got %0b want 0", out_valid);
    end
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("FAIL seq_err: got %0b want 1", err);
    end
    load_comm(3'd2);
`else
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL seq_valid: got %0b want 1", out_valid);
    end
    tests_run++;
    if (out_pkt !== mk_pkt(9'd0, 9'd0, 8'h00, 8'h00, 4'hC, 32'd30)) begin
      tests_failed++; $display("FAIL seq_pkt: got %h want payload 30", out_pkt);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL seq_err: got %0b want 0", err);
    end
    pop_one();
`endif
    tests_run++;
    if (drop_cnt !== 16'(exp_drop)) begin
      tests_failed++; $display("FAIL seq_drop: got %0d want %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_abort();
    load_comm(3'd3);
    in_eject = mk_pkt(9'd0, 9'd5, 8'h00, 8'h00, 4'hE, 32'd4); tick();
    in_eject = '0;
    tick();
    newcomm = mk_comm(8'h00, 3'd0);
    tick();
    newcomm = '0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("FAIL abort_err: got %0b want 1", err);
    end
    tick(); tick(); tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL abort_valid: got %0b want 0", out_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [84:0] exp [6];
    for (int i = 0; i < 6; i++) begin
      exp[i] = mk_pkt(9'd0, 9'd7, 8'h00, 8'(i), 4'hB, 32'(100 + i));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_eject = exp[i];
      tick();
    end
    in_eject = '0;
    tick(); tick();
    exp_drop += 2;
    tests_run++;
    if (drop_cnt !== 16'(exp_drop)) begin
      tests_failed++; $display("FAIL full_drop: got %0d want %0d", drop_cnt, exp_drop);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || out_pkt !== exp[i]) begin
        tests_failed++;
        $display("FAIL full_order%0d: got v=%0b %h want %h", i, out_valid, out_pkt, exp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_empty: got %0b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_filter();
    test_reduce3();
    test_wrap();
    test_seq();
    test_abort();
    test_fifo_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
